// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX serializer between two byte sources,
// sequencing a start/busy handshake, an inter-frame idle gap and an ack watchdog.
module uart_tx_scheduler #(
  parameter int CLOCK_HZ    = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int GAP_BITS    = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       sched_busy,
  output logic       err_timeout
);

  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int GAP_CYCLES   = GAP_BITS * CLKS_PER_BIT;
  // A zero-length gap still spends one cycle in GAP.
  localparam int GAP_LAST     = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int ACK_LAST     = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 1 : 1;
  localparam int ACK_W        = $clog2(ACK_TIMEOUT + 1) + 1;
  localparam int GAP_W        = $clog2(GAP_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [ACK_W-1:0] ack_cnt;
  logic [ACK_W-1:0] ack_next;
  logic [GAP_W-1:0] gap_cnt;

  logic grant_valid;
  logic grant_sel;
  logic launch;
  logic ack_step;
  logic timeout;
  logic gap_clear;

  assign ack_next = ack_cnt + 1'b1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    launch      = 1'b0;
    ack_step    = 1'b0;
    timeout     = 1'b0;
    gap_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_valid = 1'b1;
          grant_sel   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          state_nxt   = LAUNCH;
        end
      end
      LAUNCH: begin
        launch    = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          ack_step = 1'b1;
          // The byte is dropped on timeout; there is no retry.
          if (ack_next == ACK_W'(ACK_LAST)) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          gap_clear = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      tx_data     <= 8'h00;
      grant_id    <= 1'b0;
      err_timeout <= 1'b0;
      ack_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (grant_valid) begin
        tx_data    <= grant_sel ? req1_data : req0_data;
        grant_id   <= grant_sel;
        last_grant <= grant_sel;
      end
      if (launch)        ack_cnt <= '0;
      else if (ack_step) ack_cnt <= ack_next;
      if (timeout) err_timeout <= 1'b1;
      if (gap_clear)          gap_cnt <= '0;
      else if (state == GAP)  gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Handshake outputs are masked during reset so nothing is accepted or launched then.
  assign req0_ready = rst_n & grant_valid & ~grant_sel;
  assign req1_ready = rst_n & grant_valid & grant_sel;
  assign tx_start   = rst_n & launch;
  assign sched_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus a randomized run checked
// against a cycle-arithmetic model of arbitration, launch and gap timing.
module tb_uart_tx_scheduler;

  localparam int CPB     = 50_000_000 / 115200;  // 434 clocks per bit
  localparam int GAP_CYC = CPB;                   // GAP_BITS = 1
  localparam int FRAME   = 10 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, tx_start, tx_busy, grant_id, sched_busy, err_timeout;
  logic [7:0] tx_data;

  logic       req0_valid_b, req1_valid_b;
  logic [7:0] req0_data_b, req1_data_b;
  logic       req0_ready_b, req1_ready_b, tx_start_b, tx_busy_b, grant_id_b, sched_busy_b, err_timeout_b;
  logic [7:0] tx_data_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .sched_busy(sched_busy), .err_timeout(err_timeout)
  );

  uart_tx_scheduler #(.GAP_BITS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid_b), .req0_data(req0_data_b), .req0_ready(req0_ready_b),
    .req1_valid(req1_valid_b), .req1_data(req1_data_b), .req1_ready(req1_ready_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b),
    .grant_id(grant_id_b), .sched_busy(sched_busy_b), .err_timeout(err_timeout_b)
  );

  // Serializer models: busy for ser_len cycles starting the cycle after tx_start.
  int ser_len = FRAME;
  bit ser_ack = 1'b1;
  int ser_cnt = 0;
  always @(posedge clk)
    if (!rst_n)                   ser_cnt <= 0;
    else if (tx_start && ser_ack) ser_cnt <= ser_len;
    else if (ser_cnt > 0)         ser_cnt <= ser_cnt - 1;
  assign tx_busy = (ser_cnt != 0);

  localparam int SER_LEN_B = 20;
  int ser_cnt_b = 0;
  always @(posedge clk)
    if (!rst_n)            ser_cnt_b <= 0;
    else if (tx_start_b)   ser_cnt_b <= SER_LEN_B;
    else if (ser_cnt_b > 0) ser_cnt_b <= ser_cnt_b - 1;
  assign tx_busy_b = (ser_cnt_b != 0);

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits for a tx_start pulse on dut; returns its cycle, byte and grant.
  task automatic wait_start(input string tag, input int limit, output int t,
                            output logic [7:0] d, output logic g);
    bit seen = 1'b0;
    t = -1;
    d = 8'h00;
    g = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1'b1;
        t    = cyc;
        d    = tx_data;
        g    = grant_id;
      end
      tick();
    end
    check(tag, int'(seen), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdy0"},  int'(req0_ready), 0);
    check({tag, "_rdy1"},  int'(req1_ready), 0);
    check({tag, "_start"}, int'(tx_start), 0);
    check({tag, "_data"},  int'(tx_data), 0);
    check({tag, "_gid"},   int'(grant_id), 0);
    check({tag, "_busy"},  int'(sched_busy), 0);
    check({tag, "_err"},   int'(err_timeout), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t, t_prev, ts, n_rdy, n_start, rdy_at;
    logic [7:0] d, last_d;
    logic       g;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req1_valid = 1'b0; req1_data = 8'h00;
    req0_valid_b = 1'b0; req0_data_b = 8'h00; req1_valid_b = 1'b0; req1_data_b = 8'h00;

    // 1: reset with both valid high; req0 wins the first tie.
    req0_valid = 1'b1; req0_data = 8'h55; req1_valid = 1'b1; req1_data = 8'hAA;
    tick();
    tick();
    @(negedge clk);
    check_reset_values("t1_rst");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_rdy0", int'(req0_ready), 1);
    check("t1_rdy1", int'(req1_ready), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("t1_start", int'(tx_start), 1);
    check("t1_data",  int'(tx_data), 8'h55);
    check("t1_gid",   int'(grant_id), 0);
    check("t1_rdy1_launch", int'(req1_ready), 0);
    tick();

    // 2: both held; grants alternate and launches are one frame + gap + 3 apart.
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hA1; req1_valid = 1'b1; req1_data = 8'hB2;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_start("t2_seen", FRAME + GAP_CYC + 50, t, d, g);
      check("t2_gid",  int'(g), k % 2);
      check("t2_data", int'(d), (k % 2 == 1) ? 8'hB2 : 8'hA1);
      if (k > 0) check("t2_spacing", t - t_prev, FRAME + GAP_CYC + 3);
      t_prev = t;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 3: serializer never acknowledges.
    do_reset();
    ser_ack = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h11;
    wait_start("t3_seen", 10, ts, d, g);
    req0_valid = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 15) begin
        check("t3_err_early", int'(err_timeout), 0);
        check("t3_busy_early", int'(sched_busy), 1);
      end
      if (n == 16) begin
        check("t3_err", int'(err_timeout), 1);
        check("t3_idle", int'(sched_busy), 0);
      end
      tick();
    end
    ser_ack = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h3C;
    wait_start("t3_next_seen", 10, t, d, g);
    req1_valid = 1'b0;
    check("t3_next_data", int'(d), 8'h3C);
    check("t3_next_gid",  int'(g), 1);
    @(negedge clk);
    check("t3_err_sticky", int'(err_timeout), 1);
    tick();

    // 4: reset while the 3C frame is in WAIT_DONE.
    tick();
    @(negedge clk);
    check("t4_in_frame", int'(sched_busy), 1);
    check("t4_ser_busy", int'(tx_busy), 1);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check_reset_values("t4_rst");
    tick();
    rst_n = 1'b1;
    ser_len = 50;
    req1_valid = 1'b1; req1_data = 8'h7E;
    @(negedge clk);
    check("t4_rdy1", int'(req1_ready), 1);
    check("t4_rdy0", int'(req0_ready), 0);
    tick();
    req1_valid = 1'b0;
    wait_start("t4_seen", 5, ts, d, g);
    check("t4_data", int'(d), 8'h7E);
    check("t4_gid",  int'(g), 1);

    // 5: one-cycle req0 pulse during GAP is ignored; the next byte goes once.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
      tick();
    end
    tick();
    tick();
    req0_valid = 1'b1; req0_data = 8'h99;
    @(negedge clk);
    check("t5_pulse_rdy", int'(req0_ready), 0);
    check("t5_in_gap", int'(sched_busy), 1);
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_data = 8'hC4;
    n_rdy = 0; n_start = 0; rdy_at = -1; last_d = 8'h00;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        n_rdy++;
        rdy_at = cyc;
      end
      if (tx_start) begin
        n_start++;
        last_d = tx_data;
      end
      tick();
      if (rdy_at >= 0) req0_valid = 1'b0;
    end
    check("t5_ready_count", n_rdy, 1);
    check("t5_start_count", n_start, 1);
    check("t5_data", int'(last_d), 8'hC4);
    // IDLE returns frame + 2 + GAP_CYCLES after the previous launch.
    check("t5_idle_time", rdy_at - ts, 50 + 2 + GAP_CYC);

    // Randomized run against the arithmetic model.
    begin
      int   m_idle_at, m_start_at, f;
      logic m_last, m_gid, win, granted, idle;
      logic [7:0] m_data;
      do_reset();
      m_idle_at = 0; m_start_at = -1; m_last = 1'b1; m_gid = 1'b0; m_data = 8'h00;
      for (int it = 0; it < 12000; it++) begin
        @(negedge clk);
        idle    = (cyc >= m_idle_at);
        granted = idle && (req0_valid || req1_valid);
        win     = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        check("rnd_rdy0",  int'(req0_ready), int'(granted && !win));
        check("rnd_rdy1",  int'(req1_ready), int'(granted && win));
        check("rnd_busy",  int'(sched_busy), int'(!idle));
        check("rnd_start", int'(tx_start), int'(cyc == m_start_at));
        check("rnd_data",  int'(tx_data), int'(m_data));
        check("rnd_gid",   int'(grant_id), int'(m_gid));
        if (granted) begin
          m_last     = win;
          m_gid      = win;
          m_data     = win ? req1_data : req0_data;
          m_start_at = cyc + 1;
          f          = int'($urandom_range(1, 40));
          ser_len    = f;
          m_idle_at  = cyc + f + 3 + GAP_CYC;
        end
        tick();
        if (granted && !win) begin
          req0_valid = ($urandom_range(0, 3) == 0);
          req0_data  = 8'($urandom);
        end else if (req0_valid) begin
          if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req0_valid = 1'b1;
          req0_data  = 8'($urandom);
        end
        if (granted && win) begin
          req1_valid = ($urandom_range(0, 3) == 0);
          req1_data  = 8'($urandom);
        end else if (req1_valid) begin
          if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req1_valid = 1'b1;
          req1_data  = 8'($urandom);
        end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check("rnd_no_err", int'(err_timeout), 0);
      tick();
    end

    // 6: zero-gap build; two req1 bytes back to back, in order.
    begin
      int         starts[2];
      logic [7:0] bytes[2];
      int         n;
      bit         rdy;
      n = 0;
      req1_valid_b = 1'b1; req1_data_b = 8'h01;
      for (int i = 0; i < 200 && n < 2; i++) begin
        @(negedge clk);
        rdy = req1_ready_b;
        if (tx_start_b) begin
          starts[n] = cyc;
          bytes[n]  = tx_data_b;
          n++;
        end
        tick();
        if (rdy) begin
          if (req1_data_b == 8'h01) req1_data_b = 8'h02;
          else                      req1_valid_b = 1'b0;
        end
      end
      req1_valid_b = 1'b0;
      check("t6_count", n, 2);
      check("t6_byte0", int'(bytes[0]), 8'h01);
      check("t6_byte1", int'(bytes[1]), 8'h02);
      // GAP still occupies one cycle, so spacing is frame + 4.
      check("t6_spacing", starts[1] - starts[0], SER_LEN_B + 4);
      check("t6_gid", int'(grant_id_b), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
